// File: rtl/bk_subtractor_pipe.sv
// Two-stage a - b subtractor: Brent-Kung lower half, carry-select upper half.
// Valid/ready on both ends; results leave in order.
module bk_add #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  function automatic int top_span(input int n);
    int d;
    d = 1;
    while (4 * d <= n) d = d * 2;
    return d;
  endfunction

  localparam int TOPD = top_span(N);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N-1:0] w_gg;
  logic [N-1:0] w_pp;

  always_comb begin
    w_g  = a & b;
    w_p  = a ^ b;
    w_gg = w_g;
    w_pp = w_p;
    // Fold the carry-in into bit 0 so the prefix outputs are the carries.
    w_gg[0] = w_g[0] | (w_p[0] & cin);
    for (int d = 1; d < N; d = d * 2) begin
      for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
        w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
        w_pp[i] = w_pp[i] & w_pp[i-d];
      end
    end
    for (int d = TOPD; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
        w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
        w_pp[i] = w_pp[i] & w_pp[i-d];
      end
    end
    sum[0] = w_p[0] ^ cin;
    for (int i = 1; i < N; i++) begin
      sum[i] = w_p[i] ^ w_gg[i-1];
    end
    cout = w_gg[N-1];
  end

endmodule

module bk_subtractor_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int HI = WIDTH - SPLIT;

  logic             r_s1_valid;
  logic [SPLIT-1:0] r_diff_lo;
  logic             r_carry_lo;
  logic [HI-1:0]    r_a_hi;
  logic [HI-1:0]    r_nb_hi;
  logic             r_sa;
  logic             r_sb;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_overflow;

  logic             w_s2_can_load;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_nb;
  logic [SPLIT-1:0] w_lo_sum;
  logic             w_lo_cout;
  logic [HI-1:0]    w_hi0;
  logic [HI-1:0]    w_hi1;
  logic             w_c0;
  logic             w_c1;
  logic [HI-1:0]    w_hi_sel;
  logic             w_c_fin;

  assign w_s2_can_load = !r_s2_valid || out_ready;
  assign w_s1_adv      = r_s1_valid && w_s2_can_load;
  assign in_ready      = !rst && (!r_s1_valid || w_s2_can_load);
  assign w_in_fire     = in_valid && in_ready;
  assign w_nb          = ~b;

  bk_add #(.N(SPLIT)) u_lo (
    .a    (a[SPLIT-1:0]),
    .b    (w_nb[SPLIT-1:0]),
    .cin  (1'b1),
    .sum  (w_lo_sum),
    .cout (w_lo_cout)
  );

  bk_add #(.N(HI)) u_hi0 (
    .a    (r_a_hi),
    .b    (r_nb_hi),
    .cin  (1'b0),
    .sum  (w_hi0),
    .cout (w_c0)
  );

  bk_add #(.N(HI)) u_hi1 (
    .a    (r_a_hi),
    .b    (r_nb_hi),
    .cin  (1'b1),
    .sum  (w_hi1),
    .cout (w_c1)
  );

  assign w_hi_sel = r_carry_lo ? w_hi1 : w_hi0;
  assign w_c_fin  = r_carry_lo ? w_c1 : w_c0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_diff_lo  <= '0;
      r_carry_lo <= 1'b0;
      r_a_hi     <= '0;
      r_nb_hi    <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_diff_lo  <= w_lo_sum;
      r_carry_lo <= w_lo_cout;
      r_a_hi     <= a[WIDTH-1:SPLIT];
      r_nb_hi    <= w_nb[WIDTH-1:SPLIT];
      r_sa       <= a[WIDTH-1];
      r_sb       <= b[WIDTH-1];
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_diff     <= {w_hi_sel, r_diff_lo};
      r_borrow   <= ~w_c_fin;
      r_overflow <= (r_sa != r_sb) && (w_hi_sel[HI-1] != r_sa);
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// Bench for bk_subtractor_pipe: directed table, stall/reset
// sequences, and a randomized stream against an arithmetic model.
module tb_bk_subtractor_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        br;
    logic        ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bk_subtractor_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] x, input logic [31:0] y);
    vec_t   v;
    longint sr;
    v.a  = x;
    v.b  = y;
    v.d  = x - y;
    v.br = (x < y);
    sr   = longint'($signed(x)) - longint'($signed(y));
    v.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    @(negedge clk);
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    out_ready = 1'b1;
    #1;
    check({name, " in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
      if (out_valid || cyc > 10) break;
    end
    check({name, " latency"}, 64'(cyc), 64'd2);
    check({name, " result"}, {31'd0, diff, borrow},
          {31'd0, v.d, v.br});
    check({name, " overflow"}, {63'd0, overflow}, {63'd0, v.ov});
  endtask

  vec_t tbl[5];
  vec_t q[$];

  initial begin
    vec_t   e;
    logic   hold;
    logic [31:0] hold_d;
    int     guard;

    tbl[0] = '{32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    tbl[1] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[2] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    tbl[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1};
    tbl[4] = '{32'h12340000, 32'h0000FFFF, 32'h12330001, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset outputs", {31'd0, diff, borrow}, 64'd0);
    check("reset overflow", {63'd0, overflow}, 64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: three ops with the consumer stalled
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    a = 32'd10; b = 32'd4;
    #1;
    check("bp in_ready one held", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    a = 32'd0; b = 32'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp full in_ready", {63'd0, in_ready}, 64'd0);
      check("bp hold", {31'd0, diff, out_valid}, {31'd0, 32'd2, 1'b1});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp second", {31'd0, diff, out_valid}, {31'd0, 32'd6, 1'b1});
    @(negedge clk);
    check("bp third", {30'd0, diff, borrow, out_valid},
          {30'd0, 32'hFFFFFFF9, 1'b1, 1'b1});
    @(negedge clk);
    check("bp drained", {63'd0, out_valid}, 64'd0);

    // Reset with two ops in flight
    out_ready = 1'b0; in_valid = 1'b1; a = 32'd9; b = 32'd1;
    @(negedge clk);
    a = 32'd8; b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-rst out_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst flush out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      hold = hold | out_valid;
    end
    check("no stale after rst", {63'd0, hold}, 64'd0);

    // Randomized stream against the model
    hold = 1'b0; hold_d = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (hold) check("stall stable", {32'd0, diff}, {32'd0, hold_d});
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = $urandom;
      b         = (c % 7 == 0) ? a : $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand unexpected", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("rand result", {30'd0, diff, borrow, overflow},
                {30'd0, e.d, e.br, e.ov});
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b));
      hold   = out_valid && !out_ready;
      hold_d = diff;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        check("drain result", {30'd0, diff, borrow, overflow},
              {30'd0, e.d, e.br, e.ov});
      end
      @(negedge clk);
      guard++;
    end
    check("drain empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bk_subtractor_pipe.md
Name: bk_subtractor_pipe

Overview:
Pipelined 32-bit subtractor computing a - b as a + ~b + 1. The lower half uses a Brent-Kung prefix carry network. The upper half uses a carry-select pair of Brent-Kung adders.
- This is the subtraction direction of the team's Brent-Kung carry-select adder.
- Sits beside the adder in the arithmetic datapath.
- Uses valid/ready handshakes on both ends, so it can be stalled by a downstream consumer.

Parameters:
WIDTH, 32, operand width; must be even, minimum 4.
SPLIT, WIDTH/2, bit index where the lower Brent-Kung half ends and the carry-select upper half begins (derived; do not override).

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair a/b is valid this cycle.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  minuend, unsigned or two's complement.
b  input  WIDTH  subtrahend.
out_valid  output  1  diff/borrow/overflow are valid.
out_ready  input  1  consumer accepts the result this cycle.
diff  output  WIDTH  a - b modulo 2^WIDTH.
borrow  output  1  unsigned borrow: 1 when a < b unsigned; equals the inverted carry-out.
overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- Reset (rst=1 at a clk edge): both stage valid flags clear. out_valid=0, diff=0, borrow=0, overflow=0. in_ready goes to 1 in the first cycle after rst deasserts.
- A reset asserted mid-operation discards all in-flight results. No partial result is ever presented.
- Input handshake: a transfer occurs on a clk edge where in_valid && in_ready. a and b are sampled only on transfer.
- Output handshake: a result is consumed on a clk edge where out_valid && out_ready.
- Stage 1 (registered on input transfer):
  - lower SPLIT bits of a + ~b with carry-in 1, through a Brent-Kung generate/propagate prefix tree;
  - registers diff_lo, carry_lo (carry out of bit SPLIT-1), a_hi, ~b_hi, and the a/b sign bits.
- Stage 2 (registered when stage 1 advances):
  - two upper Brent-Kung sums, one with carry-in 0 and one with carry-in 1;
  - carry_lo selects both the upper sum and the final carry;
  - registers diff, borrow = ~carry_final, and overflow.
- Latency: a result appears on out_valid exactly 2 cycles after its input transfer when there is no backpressure.
- Throughput: one operation per cycle while out_ready=1.
- Stall rules:
  - stage 2 may load when it is empty or is being consumed this cycle;
  - stage 1 may load when it is empty or is advancing into stage 2 this cycle;
  - in_ready = !s1_valid || s2_can_load. This is combinational from out_ready; no combinational path exists from in_valid.
- Simultaneous consume and load in the same cycle on either stage: the old value leaves and the new value enters; no bubble is inserted.
- While out_valid=1 and out_ready=0, diff/borrow/overflow hold stable.
- Results leave in input order.
- Full pipeline (both stages valid, out_ready=0): in_ready=0, and in_valid is ignored.
- Empty pipeline: out_valid=0. diff/borrow/overflow hold their last values and are don't-care.
- Wrap-around: diff is modulo 2^WIDTH, with no saturation.
- a == b gives diff=0 and borrow=0.
- The carry-select mux must never be bypassed. The carry out of bit SPLIT-1 alone determines the upper half.

Test Plan:
- After rst, hold in_valid with a=0x00000001, b=0x00000001 and out_ready=1. Expect out_valid exactly 2 cycles after the transfer with diff=0x00000000, borrow=0, overflow=0.
- Send a=0x00000000, b=0x00000001 → diff=0xFFFFFFFF, borrow=1, overflow=0.
- Send a=0x80000000, b=0x00000001 → diff=0x7FFFFFFF, borrow=0, overflow=1.
- Send a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, borrow=1, overflow=1.
- Send a=0x12340000, b=0x0000FFFF → diff=0x12330001, borrow=0. This exercises the split carry_lo=0 path, and the upper half must select the carry-in-0 sum.
- Backpressure and reset, one back-to-back stream:
  - stream 3 ops (5-3, 10-4, 0-7) with out_ready=0;
  - expect in_ready=0 once 2 are held, the third is held off, and diff stays 0x00000002 stable;
  - release out_ready → results 0x00000002, 0x00000006, 0xFFFFFFF9 (borrow=1) in order, one per cycle;
  - then assert rst with 2 ops in flight → out_valid=0 next cycle, and no stale result after rst drops.
